// File: rtl/wb_coalesce_fifo.sv
// wb_coalesce_fifo: writeback coalescing FIFO between multi-lane issue and register-file write ports.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   InValid/InRd/InData - per-lane writeback group, lane 0 oldest
//   InReady           - whole group accepted this cycle
//   WStall            - register file busy, hold the drain
//   we3/a3/wd3        - per-port register-file write, port 0 oldest
//   RAddr1/2, Busy1/2 - hazard query: register has a queued write
//   Count, Empty      - occupancy
module wb_coalesce_fifo #(
  parameter int XLEN   = 32,
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int WPORTS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        InValid,
  input  logic [LANES*5-1:0]      InRd,
  input  logic [LANES*XLEN-1:0]   InData,
  output logic                    InReady,
  input  logic                    WStall,
  output logic [WPORTS-1:0]       we3,
  output logic [WPORTS*5-1:0]     a3,
  output logic [WPORTS*XLEN-1:0]  wd3,
  input  logic [4:0]              RAddr1,
  input  logic [4:0]              RAddr2,
  output logic                    Busy1,
  output logic                    Busy2,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]      rdMem   [DEPTH];
  logic [XLEN-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   pushCnt, nDrain;
  logic [LANES-1:0] laneTake;
  logic [AW-1:0]   laneSlot [LANES];
  logic [WPORTS-1:0] portOn;
  logic [AW-1:0]   portSlot [WPORTS];

  // Push side: all-or-nothing space check, then compact the surviving lanes onto the tail.
  always_comb begin
    InReady = (CW'(DEPTH) - Count) >= CW'(LANES);
    pushCnt = '0;
    for (int l = 0; l < LANES; l++) begin
      laneTake[l] = InReady && InValid[l] && (InRd[l*5 +: 5] != 5'd0);
      laneSlot[l] = tail + AW'(pushCnt);
      pushCnt = pushCnt + CW'(laneTake[l]);
    end
  end

  // Drain side: present the oldest entries; a younger same-register write in the group masks older ones.
  always_comb begin
    nDrain = WStall ? '0 : (Count < CW'(WPORTS) ? Count : CW'(WPORTS));
    we3 = '0;
    a3 = '0;
    wd3 = '0;
    for (int p = 0; p < WPORTS; p++) begin
      portSlot[p] = head + AW'(p);
      portOn[p] = CW'(p) < nDrain;
    end
    for (int p = 0; p < WPORTS; p++) begin
      we3[p] = portOn[p];
      for (int q = p + 1; q < WPORTS; q++)
        if (portOn[q] && rdMem[portSlot[q]] == rdMem[portSlot[p]]) we3[p] = 1'b0;
      a3[p*5 +: 5] = portOn[p] ? rdMem[portSlot[p]] : 5'd0;
      wd3[p*XLEN +: XLEN] = portOn[p] ? dataMem[portSlot[p]] : '0;
    end
  end

  // Hazard query over held entries only; this cycle's push group is not yet visible.
  always_comb begin
    Busy1 = 1'b0;
    Busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      Busy1 = Busy1 || (vld[i] && rdMem[i] == RAddr1);
      Busy2 = Busy2 || (vld[i] && rdMem[i] == RAddr2);
    end
    Busy1 = Busy1 && (RAddr1 != 5'd0);
    Busy2 = Busy2 && (RAddr2 != 5'd0);
  end

  assign Empty = Count == '0;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
      vld   <= '0;
    end else begin
      for (int p = 0; p < WPORTS; p++)
        if (portOn[p]) vld[portSlot[p]] <= 1'b0;
      for (int l = 0; l < LANES; l++)
        if (laneTake[l]) vld[laneSlot[l]] <= 1'b1;
      head  <= head + AW'(nDrain);
      tail  <= tail + AW'(pushCnt);
      Count <= Count + pushCnt - nDrain;
    end

  // Payload needs no reset: validity is carried by vld and Count.
  always_ff @(posedge clk)
    for (int l = 0; l < LANES; l++)
      if (laneTake[l]) begin
        rdMem[laneSlot[l]]   <= InRd[l*5 +: 5];
        dataMem[laneSlot[l]] <= InData[l*XLEN +: XLEN];
      end
endmodule

// File: tb/tb_wb_coalesce_fifo.sv
// tb_wb_coalesce_fifo: directed and randomized checks of wb_coalesce_fifo with one and two write ports.
module tb_wb_coalesce_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;
  logic [1:0] inValid;
  logic [9:0] inRd;
  logic [63:0] inData;
  logic wStall;
  logic [4:0] rAddr1, rAddr2;
  logic rdy0, busyA0, busyB0, empty0, rdy1, busyA1, busyB1, empty1;
  logic [0:0] we0;
  logic [4:0] a0;
  logic [31:0] wd0;
  logic [1:0] we1;
  logic [9:0] a1;
  logic [63:0] wd1;
  logic [3:0] cnt0, cnt1;
  int compared = 0;
  int mismatched = 0;

  wb_coalesce_fifo #(.XLEN(32), .LANES(2), .DEPTH(8), .WPORTS(1)) u0 (
    .clk(clk), .reset(rstN), .InValid(inValid), .InRd(inRd), .InData(inData), .InReady(rdy0),
    .WStall(wStall), .we3(we0), .a3(a0), .wd3(wd0), .RAddr1(rAddr1), .RAddr2(rAddr2),
    .Busy1(busyA0), .Busy2(busyB0), .Count(cnt0), .Empty(empty0));
  wb_coalesce_fifo #(.XLEN(32), .LANES(2), .DEPTH(8), .WPORTS(2)) u1 (
    .clk(clk), .reset(rstN), .InValid(inValid), .InRd(inRd), .InData(inData), .InReady(rdy1),
    .WStall(wStall), .we3(we1), .a3(a1), .wd3(wd1), .RAddr1(rAddr1), .RAddr2(rAddr2),
    .Busy1(busyA1), .Busy2(busyB1), .Count(cnt1), .Empty(empty1));

  logic [1:0] weK [2];
  logic [9:0] aK [2];
  logic [63:0] wdK [2];
  logic [3:0] cntK [2];
  logic rdyK [2], emptyK [2], busyAK [2], busyBK [2];
  assign weK[0] = {1'b0, we0};
  assign aK[0] = {5'd0, a0};
  assign wdK[0] = {32'd0, wd0};
  assign cntK[0] = cnt0;
  assign rdyK[0] = rdy0;
  assign emptyK[0] = empty0;
  assign busyAK[0] = busyA0;
  assign busyBK[0] = busyB0;
  assign weK[1] = we1;
  assign aK[1] = a1;
  assign wdK[1] = wd1;
  assign cntK[1] = cnt1;
  assign rdyK[1] = rdy1;
  assign emptyK[1] = empty1;
  assign busyAK[1] = busyA1;
  assign busyBK[1] = busyB1;

  task automatic setIdle();
    inValid = 2'b00;
    inRd = '0;
    inData = '0;
    rAddr1 = 5'd0;
    rAddr2 = 5'd0;
  endtask

  task automatic setPush(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
    inValid = v;
    inRd = {r1, r0};
    inData = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    setIdle();
    wStall = 1'b0;
    rAddr1 = 5'd5;
    rAddr2 = 5'd6;
    #2;
    compared++; if (cnt0 !== 4'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", cnt0); end
    compared++; if (empty0 !== 1'b1) begin mismatched++; $display("FAIL reset_empty got %b want 1", empty0); end
    compared++; if (rdy0 !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", rdy0); end
    compared++; if ({we0, a0, wd0} !== '0) begin mismatched++; $display("FAIL reset_port got we=%b a=%0d wd=%h want zeros", we0, a0, wd0); end
    compared++; if ({busyA0, busyB0, busyA1, busyB1} !== 4'b0) begin mismatched++; $display("FAIL reset_busy got %b%b%b%b want 0000", busyA0, busyB0, busyA1, busyB1); end
    compared++; if ({we1, a1, wd1, cnt1} !== '0) begin mismatched++; $display("FAIL reset_u1 got we=%b a=%h cnt=%0d want zeros", we1, a1, cnt1); end
    tick();
    rstN = 1'b1;
    setIdle();
  endtask

  task automatic test_basic();
    setPush(2'b11, 5'd5, 32'hA, 5'd6, 32'hB);
    #1;
    compared++; if (we0 !== 1'b0) begin mismatched++; $display("FAIL basic_nobypass got we=%b want 0", we0); end
    tick();
    setIdle();
    #1;
    compared++; if ({we0, a0, wd0} !== {1'b1, 5'd5, 32'hA}) begin mismatched++; $display("FAIL basic_first got we=%b a=%0d wd=%h want 1/5/a", we0, a0, wd0); end
    compared++; if (cnt0 !== 4'd2) begin mismatched++; $display("FAIL basic_count got %0d want 2", cnt0); end
    tick();
    compared++; if ({we0, a0, wd0} !== {1'b1, 5'd6, 32'hB}) begin mismatched++; $display("FAIL basic_second got we=%b a=%0d wd=%h want 1/6/b", we0, a0, wd0); end
    tick();
    compared++; if (empty0 !== 1'b1 || we0 !== 1'b0) begin mismatched++; $display("FAIL basic_empty got empty=%b we=%b want 1/0", empty0, we0); end
  endtask

  task automatic test_drop();
    setPush(2'b11, 5'd0, 32'hDEAD, 5'd7, 32'h1);
    tick();
    setIdle();
    #1;
    compared++; if (cnt0 !== 4'd1) begin mismatched++; $display("FAIL drop_count got %0d want 1", cnt0); end
    compared++; if ({we0, a0, wd0} !== {1'b1, 5'd7, 32'h1}) begin mismatched++; $display("FAIL drop_write got we=%b a=%0d wd=%h want 1/7/1", we0, a0, wd0); end
    compared++; if (we1 !== 2'b01 || a1[4:0] !== 5'd7) begin mismatched++; $display("FAIL drop_u1 got we=%b a=%0d want 01/7", we1, a1[4:0]); end
    tick();
    compared++; if (we0 !== 1'b0 || empty0 !== 1'b1) begin mismatched++; $display("FAIL drop_after got we=%b empty=%b want 0/1", we0, empty0); end
  endtask

  task automatic test_waw();
    setPush(2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
    tick();
    setIdle();
    #1;
    compared++; if (we1 !== 2'b10) begin mismatched++; $display("FAIL waw_we got %b want 10", we1); end
    compared++; if (a1[9:5] !== 5'd3 || wd1[63:32] !== 32'h22) begin mismatched++; $display("FAIL waw_port1 got a=%0d wd=%h want 3/22", a1[9:5], wd1[63:32]); end
    compared++; if ({we0, a0, wd0} !== {1'b1, 5'd3, 32'h11}) begin mismatched++; $display("FAIL waw_single got we=%b a=%0d wd=%h want 1/3/11", we0, a0, wd0); end
    tick();
    compared++; if (cnt1 !== 4'd0 || we1 !== 2'b00) begin mismatched++; $display("FAIL waw_drained got cnt=%0d we=%b want 0/00", cnt1, we1); end
    compared++; if ({we0, a0, wd0} !== {1'b1, 5'd3, 32'h22}) begin mismatched++; $display("FAIL waw_single2 got we=%b a=%0d wd=%h want 1/3/22", we0, a0, wd0); end
    tick();
  endtask

  task automatic test_full();
    wStall = 1'b1;
    for (int g = 0; g < 3; g++) begin
      setPush(2'b11, 5'(2*g+1), 32'h100 + 32'(2*g+1), 5'(2*g+2), 32'h100 + 32'(2*g+2));
      tick();
    end
    setIdle();
    #1;
    compared++; if (cnt0 !== 4'd6 || rdy0 !== 1'b1) begin mismatched++; $display("FAIL full_six got cnt=%0d rdy=%b want 6/1", cnt0, rdy0); end
    setPush(2'b11, 5'd7, 32'h107, 5'd8, 32'h108);
    tick();
    setIdle();
    #1;
    compared++; if (cnt0 !== 4'd8 || rdy0 !== 1'b0) begin mismatched++; $display("FAIL full_eight got cnt=%0d rdy=%b want 8/0", cnt0, rdy0); end
    setPush(2'b11, 5'd9, 32'h109, 5'd10, 32'h10A);
    tick();
    setIdle();
    #1;
    compared++; if (cnt0 !== 4'd8 || cnt1 !== 4'd8) begin mismatched++; $display("FAIL full_refuse got cnt0=%0d cnt1=%0d want 8/8", cnt0, cnt1); end
    wStall = 1'b0;
    #1;
    for (int i = 1; i <= 8; i++) begin
      compared++;
      if ({we0, a0, wd0} !== {1'b1, 5'(i), 32'h100 + 32'(i)}) begin
        mismatched++;
        $display("FAIL full_drain%0d got we=%b a=%0d wd=%h want 1/%0d/%h", i, we0, a0, wd0, i, 32'h100 + 32'(i));
      end
      tick();
    end
    compared++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin mismatched++; $display("FAIL full_empty got %b/%b want 1/1", empty0, empty1); end
  endtask

  task automatic test_busy();
    wStall = 1'b1;
    setPush(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    tick();
    setIdle();
    rAddr1 = 5'd9;
    rAddr2 = 5'd4;
    #1;
    compared++; if (busyA0 !== 1'b1 || busyB0 !== 1'b0) begin mismatched++; $display("FAIL busy_held got %b%b want 10", busyA0, busyB0); end
    setPush(2'b11, 5'd4, 32'h44, 5'd4, 32'h45);
    #1;
    compared++; if (busyB0 !== 1'b0) begin mismatched++; $display("FAIL busy_nopush got %b want 0", busyB0); end
    tick();
    setIdle();
    wStall = 1'b0;
    rAddr1 = 5'd9;
    rAddr2 = 5'd0;
    #1;
    compared++; if ({busyA0, busyB0, we0, a0} !== {1'b1, 1'b0, 1'b1, 5'd9}) begin mismatched++; $display("FAIL busy_drain got b1=%b b2=%b we=%b a=%0d want 1/0/1/9", busyA0, busyB0, we0, a0); end
    tick();
    compared++; if (busyA0 !== 1'b0) begin mismatched++; $display("FAIL busy_after got %b want 0", busyA0); end
    tick();
    tick();
    setIdle();
  endtask

  task automatic test_reset_mid();
    wStall = 1'b1;
    setPush(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    setPush(2'b11, 5'd3, 32'h3, 5'd4, 32'h4);
    tick();
    setPush(2'b01, 5'd5, 32'h5, 5'd0, 32'h0);
    tick();
    setIdle();
    wStall = 1'b0;
    #1;
    compared++; if (cnt0 !== 4'd5 || we0 !== 1'b1) begin mismatched++; $display("FAIL mid_pre got cnt=%0d we=%b want 5/1", cnt0, we0); end
    #1;
    rstN = 1'b0;
    #1;
    compared++; if ({cnt0, we0, a0, wd0, rdy0, empty0} !== {4'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1}) begin mismatched++; $display("FAIL mid_reset got cnt=%0d we=%b rdy=%b empty=%b want 0/0/1/1", cnt0, we0, rdy0, empty0); end
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++; if (we0 !== 1'b0 || we1 !== 2'b00 || cnt0 !== 4'd0) begin mismatched++; $display("FAIL mid_stale%0d got we0=%b we1=%b cnt=%0d want 0/00/0", i, we0, we1, cnt0); end
    end
  endtask

  task automatic test_random();
    logic [4:0] qRd [2][$];
    logic [31:0] qDat [2][$];
    for (int c = 0; c < 500; c++) begin
      inValid = 2'($urandom);
      inRd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      inData = {$urandom, $urandom};
      wStall = ($urandom_range(0, 3) == 0);
      rAddr1 = 5'($urandom_range(0, 7));
      rAddr2 = 5'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < 2; k++) begin
        int sz, n;
        bit expRdy, expB1, expB2, expWe;
        sz = qRd[k].size();
        expRdy = (8 - sz) >= 2;
        n = wStall ? 0 : (sz < k + 1 ? sz : k + 1);
        expB1 = 1'b0;
        expB2 = 1'b0;
        foreach (qRd[k][i]) begin
          if (rAddr1 != 0 && qRd[k][i] == rAddr1) expB1 = 1'b1;
          if (rAddr2 != 0 && qRd[k][i] == rAddr2) expB2 = 1'b1;
        end
        compared++; if (cntK[k] !== 4'(sz) || emptyK[k] !== (sz == 0)) begin mismatched++; $display("FAIL rnd_count u%0d c%0d got %0d want %0d", k, c, cntK[k], sz); end
        compared++; if (rdyK[k] !== expRdy) begin mismatched++; $display("FAIL rnd_ready u%0d c%0d got %b want %b", k, c, rdyK[k], expRdy); end
        compared++; if (busyAK[k] !== expB1 || busyBK[k] !== expB2) begin mismatched++; $display("FAIL rnd_busy u%0d c%0d got %b%b want %b%b", k, c, busyAK[k], busyBK[k], expB1, expB2); end
        for (int p = 0; p <= k; p++) begin
          expWe = p < n;
          for (int j = p + 1; j < n; j++) if (qRd[k][j] == qRd[k][p]) expWe = 1'b0;
          compared++;
          if (weK[k][p] !== expWe) begin mismatched++; $display("FAIL rnd_we u%0d p%0d c%0d got %b want %b", k, p, c, weK[k][p], expWe); end
          else if (expWe && (aK[k][p*5 +: 5] !== qRd[k][p] || wdK[k][p*32 +: 32] !== qDat[k][p])) begin
            mismatched++;
            $display("FAIL rnd_data u%0d p%0d c%0d got %0d/%h want %0d/%h", k, p, c, aK[k][p*5 +: 5], wdK[k][p*32 +: 32], qRd[k][p], qDat[k][p]);
          end else if (p >= n && (aK[k][p*5 +: 5] !== 5'd0 || wdK[k][p*32 +: 32] !== 32'd0)) begin
            mismatched++;
            $display("FAIL rnd_idle u%0d p%0d c%0d got %0d/%h want 0/0", k, p, c, aK[k][p*5 +: 5], wdK[k][p*32 +: 32]);
          end
        end
        for (int i = 0; i < n; i++) begin
          void'(qRd[k].pop_front());
          void'(qDat[k].pop_front());
        end
        if (expRdy)
          for (int l = 0; l < 2; l++)
            if (inValid[l] && inRd[l*5 +: 5] != 5'd0) begin
              qRd[k].push_back(inRd[l*5 +: 5]);
              qDat[k].push_back(inData[l*32 +: 32]);
            end
      end
      @(posedge clk);
      #1;
    end
    setIdle();
    wStall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_waw();
    test_full();
    test_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_coalesce_fifo.md
WB_COALESCE_FIFO -- requirements
Module: wb_coalesce_fifo

Interface
REQ-001 Parameter XLEN, default 32: data width of each writeback entry.
REQ-002 Parameter LANES, default 2: issue lanes that can push writebacks per cycle, range 1..4.
REQ-003 Parameter DEPTH, default 8: FIFO entries, power of two, DEPTH >= 2*LANES.
REQ-004 Parameter WPORTS, default 1: register-file write ports drained per cycle, range 1..LANES.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 InValid  input  LANES  per-lane writeback request; lane 0 is oldest in program order.
REQ-008 InRd  input  LANES*5  per-lane destination register.
REQ-009 InData  input  LANES*XLEN  per-lane result data.
REQ-010 InReady  output  1  group push accepted this cycle.
REQ-011 WStall  input  1  register file busy; no drain this cycle.
REQ-012 we3  output  WPORTS  per-port write enable.
REQ-013 a3  output  WPORTS*5  per-port destination register.
REQ-014 wd3  output  WPORTS*XLEN  per-port write data.
REQ-015 RAddr1, RAddr2  input  5 each  hazard query registers.
REQ-016 Busy1, Busy2  output  1 each  query register has a queued write.
REQ-017 Count  output  $clog2(DEPTH)+1  valid entries held.
REQ-018 Empty  output  1  Count == 0.

Function
REQ-019 Push is all-or-nothing: InReady = (DEPTH - Count) >= LANES, independent of InValid.
REQ-020 When InReady, lanes with InValid=1 and InRd!=0 are enqueued compacted, in ascending lane order, at consecutive tail slots.
REQ-021 Lanes with InRd==0 are dropped, never enqueued, never asserting we3.
REQ-022 When InReady=0, all lanes are refused; the issuer holds them unchanged.
REQ-023 Drain count N = 0 if WStall, else min(WPORTS, Count); ports 0..N-1 present the N oldest entries, port 0 oldest.
REQ-024 we3/a3/wd3 are combinational from head entries; an entry pushed at edge t can drive a port during cycle t+1 at earliest; no same-cycle bypass.
REQ-025 WAW within a drain group: if two draining entries share a3, only the youngest asserts we3; the older still leaves the FIFO.
REQ-026 Unused ports drive we3=0, a3=0, wd3=0.
REQ-027 Simultaneous push and drain in one cycle is permitted; Count_next = Count + pushed - N; InReady uses pre-drain Count.
REQ-028 Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty resolved by Count, never by pointer equality.
REQ-029 Busy1 = 1 iff any valid entry has rd == RAddr1 (likewise Busy2/RAddr2), including entries draining this cycle; RAddr==0 yields Busy=0.
REQ-030 Busy ignores the current-cycle push group.
REQ-031 Entry payload storage needs no reset; only valid state, pointers and Count reset.
REQ-032 Order is strictly FIFO: writes reach the register file in push order across all lanes and cycles.

Reset
REQ-033 reset low asynchronously clears pointers, Count and valid state regardless of clk.
REQ-034 During and after reset: Count=0, Empty=1, InReady=1, we3=0, a3=0, wd3=0, Busy1=Busy2=0.
REQ-035 Reset asserted mid-operation discards all queued entries; no further we3 pulses for them.
REQ-036 First push accepted on first rising edge with reset high.

Verification
REQ-037 LANES=2,WPORTS=1: push {lane0 rd5=0xA, lane1 rd6=0xB} -> cycle+1 we3=1 a3=5 wd3=0xA; cycle+2 a3=6 wd3=0xB; then Empty=1.
REQ-038 Push lane0 rd0 and lane1 rd7=0x1 -> Count=1, single write to x7, never a3=0 with we3=1.
REQ-039 WPORTS=2: push {rd3=0x11, rd3=0x22} -> next cycle we3=2'b10, a3[1]=3, wd3[1]=0x22; Count returns to 0.
REQ-040 DEPTH=8,LANES=2, WStall=1, push 3 groups -> Count=6, InReady=1; fourth -> Count=8, InReady=0; release WStall -> 8 writes in order, pointers wrap correctly.
REQ-041 With rd9 queued: RAddr1=9 -> Busy1=1, RAddr2=0 -> Busy2=0; after drain Busy1=0.
REQ-042 Assert reset with Count=5 mid-drain -> immediately Count=0, we3=0, InReady=1; no stale write after release.
